instr_fetch_ctrl: RTL and testbench

INSTR_FETCH_CTRL -- requirements
Module: instr_fetch_ctrl

---
 rtl/instr_fetch_ctrl.sv | 136 +++++++++++++
 tb/tb_instr_fetch_ctrl.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch controller: presents pc to the instruction memory and registers one fetched
// instruction per cycle. Optional perf counters (fetch_count, stall_count) with FETCH_PERF_EN.
module instr_fetch_ctrl #(
  parameter logic [31:0]     RESET_PC   = 32'h0000_0000,
  parameter longint unsigned IMEM_BYTES = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  output logic        misalign_err,
  output logic        halted
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] fetch_count,
  output logic [31:0] stall_count
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    STALL = 2'd2,
    HALT  = 2'd3
  } state_t;

  // Highest word address still inside the memory; 33 bits so a full 4 GiB memory never halts.
  localparam logic [32:0] LAST_ADDR = 33'(IMEM_BYTES - 64'd4);

  state_t      state;
  state_t      state_d;
  logic [31:0] pc;
  logic [31:0] pc_d;
  logic [31:0] redirect_pc;
  logic        do_fetch;
  logic        drop_valid;
  logic        count_stall;
  logic        pc_beyond;
  logic        redirect_beyond;

  assign imem_addr       = pc;
  assign halted          = (state == HALT);
  assign redirect_pc     = {redirect_target[31:2], 2'b00};
  assign pc_beyond       = ({1'b0, pc} > LAST_ADDR);
  assign redirect_beyond = ({1'b0, redirect_pc} > LAST_ADDR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Redirect outranks everything; an out-of-range pc outranks stall so HALT is never delayed.
  always_comb begin
    state_d     = state;
    pc_d        = pc;
    do_fetch    = 1'b0;
    drop_valid  = 1'b0;
    count_stall = 1'b0;
    if (redirect_valid) begin
      pc_d       = redirect_pc;
      drop_valid = 1'b1;
      state_d    = redirect_beyond ? HALT : RUN;
    end else begin
      case (state)
        IDLE: begin
          state_d = RUN;
        end
        RUN, STALL: begin
          count_stall = stall;
          if (pc_beyond) begin
            state_d    = HALT;
            drop_valid = 1'b1;
          end else if (stall) begin
            state_d = STALL;
          end else begin
            do_fetch = 1'b1;
            pc_d     = pc + 32'd4;
            state_d  = RUN;
          end
        end
        HALT: begin
          drop_valid = 1'b1;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc           <= RESET_PC;
      if_valid     <= 1'b0;
      if_pc        <= 32'd0;
      if_instr     <= 32'd0;
      misalign_err <= 1'b0;
    end else begin
      pc           <= pc_d;
      misalign_err <= redirect_valid && (redirect_target[1:0] != 2'b00);
      if (do_fetch) begin
        if_valid <= 1'b1;
        if_pc    <= pc;
        if_instr <= imem_instr;
      end else if (drop_valid) begin
        if_valid <= 1'b0;
      end
    end
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_count <= 32'd0;
      stall_count <= 32'd0;
    end else begin
      if (do_fetch) begin
        fetch_count <= fetch_count + 32'd1;
      end
      if (count_stall) begin
        stall_count <= stall_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Scoreboard bench for instr_fetch_ctrl: a transaction-level model queues expected cycle and
// fetch results while a negedge monitor pops and compares them.
module tb_instr_fetch_ctrl;

  localparam logic [31:0] RESET_PC   = 32'h0000_0000;
  localparam longint      IMEM_BYTES = 1024;

  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_HALT = 2;

  typedef struct packed {
    logic [31:0] addr;
    logic        valid;
    logic        halt;
    logic        mis;
    logic [31:0] fcnt;
    logic [31:0] scnt;
  } cyc_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_t;

  logic        clk;
  logic        rst_n;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        misalign_err;
  logic        halted;
`ifdef FETCH_PERF_EN
  logic [31:0] fetch_count;
  logic [31:0] stall_count;
`endif

  int checks = 0;
  int errors = 0;

  cyc_t   cyc_q[$];
  fetch_t fetch_q[$];

  int          m_mode;
  logic [31:0] m_pc;
  logic        m_valid;
  logic        m_mis;
  logic [31:0] m_fcnt;
  logic [31:0] m_scnt;

  instr_fetch_ctrl #(
    .RESET_PC  (RESET_PC),
    .IMEM_BYTES(IMEM_BYTES)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_addr      (imem_addr),
    .imem_instr     (imem_instr),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_target(redirect_target),
    .if_valid       (if_valid),
    .if_pc          (if_pc),
    .if_instr       (if_instr),
    .misalign_err   (misalign_err),
    .halted         (halted)
`ifdef FETCH_PERF_EN
    ,
    .fetch_count    (fetch_count),
    .stall_count    (stall_count)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'd0) return 32'h00A2_8433;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  assign imem_instr = mem_word(imem_addr);

  function automatic logic beyond(input logic [31:0] a);
    return {32'd0, a} > 64'(IMEM_BYTES - 4);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic modelReset();
    m_mode  = M_IDLE;
    m_pc    = RESET_PC;
    m_valid = 1'b0;
    m_mis   = 1'b0;
    m_fcnt  = 32'd0;
    m_scnt  = 32'd0;
  endtask

  // One clock of stimulus; the model predicts the post-edge view, which is queued at the edge.
  task automatic applyStimulus(input logic s, input logic r, input logic [31:0] t);
    int          n_mode;
    logic [31:0] n_pc;
    logic        n_valid;
    logic        has_fetch;
    fetch_t      f;
    cyc_t        c;
    stall           = s;
    redirect_valid  = r;
    redirect_target = t;
    n_mode    = m_mode;
    n_pc      = m_pc;
    n_valid   = m_valid;
    has_fetch = 1'b0;
    f         = '0;
    if (r) begin
      n_pc    = t & 32'hFFFF_FFFC;
      n_valid = 1'b0;
      n_mode  = beyond(n_pc) ? M_HALT : M_RUN;
    end else if (m_mode == M_IDLE) begin
      n_mode = M_RUN;
    end else if (m_mode == M_RUN) begin
      if (s) m_scnt = m_scnt + 32'd1;
      if (beyond(m_pc)) begin
        n_mode  = M_HALT;
        n_valid = 1'b0;
      end else if (!s) begin
        has_fetch = 1'b1;
        f.pc      = m_pc;
        f.instr   = mem_word(m_pc);
        n_pc      = m_pc + 32'd4;
        n_valid   = 1'b1;
        m_fcnt    = m_fcnt + 32'd1;
      end
    end
    m_mis = r && (t[1:0] != 2'b00);
    @(posedge clk);
    m_mode  = n_mode;
    m_pc    = n_pc;
    m_valid = n_valid;
    c.addr  = m_pc;
    c.valid = m_valid;
    c.halt  = (m_mode == M_HALT);
    c.mis   = m_mis;
    c.fcnt  = m_fcnt;
    c.scnt  = m_scnt;
    cyc_q.push_back(c);
    if (has_fetch) fetch_q.push_back(f);
    #1;
  endtask

  // Asynchronous reset: values must be at reset state before any clock edge.
  task automatic doReset();
    rst_n = 1'b0;
    #2;
    cyc_q.delete();
    fetch_q.delete();
    modelReset();
    checkOutput("rst_imem_addr", imem_addr, RESET_PC);
    checkOutput("rst_if_valid", 32'(if_valid), 32'd0);
    checkOutput("rst_if_pc", if_pc, 32'd0);
    checkOutput("rst_if_instr", if_instr, 32'd0);
    checkOutput("rst_misalign", 32'(misalign_err), 32'd0);
    checkOutput("rst_halted", 32'(halted), 32'd0);
`ifdef FETCH_PERF_EN
    checkOutput("rst_fetch_count", fetch_count, 32'd0);
    checkOutput("rst_stall_count", stall_count, 32'd0);
`endif
    stall          = 1'b0;
    redirect_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Monitor: per-cycle observables every negedge, fetch payload whenever a new output appears.
  initial begin
    cyc_t        c;
    fetch_t      f;
    logic        prev_valid;
    logic [31:0] prev_pc;
    prev_valid = 1'b0;
    prev_pc    = 32'd0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_valid = 1'b0;
      end else begin
        if (cyc_q.size() > 0) begin
          c = cyc_q.pop_front();
          checkOutput("imem_addr", imem_addr, c.addr);
          checkOutput("if_valid", 32'(if_valid), 32'(c.valid));
          checkOutput("halted", 32'(halted), 32'(c.halt));
          checkOutput("misalign_err", 32'(misalign_err), 32'(c.mis));
`ifdef FETCH_PERF_EN
          checkOutput("fetch_count", fetch_count, c.fcnt);
          checkOutput("stall_count", stall_count, c.scnt);
`endif
        end
        if (if_valid && (!prev_valid || if_pc != prev_pc)) begin
          checks++;
          if (fetch_q.size() == 0) begin
            errors++;
            $display("[TB] FAIL unexpected_fetch: got if_pc %h expected no new fetch", if_pc);
          end else begin
            f = fetch_q.pop_front();
            checkOutput("if_pc", if_pc, f.pc);
            checkOutput("if_instr", if_instr, f.instr);
          end
        end
        prev_valid = if_valid;
        prev_pc    = if_pc;
      end
    end
  end

  initial begin
    logic [31:0] tgt;
    logic        s;
    logic        r;
    rst_n           = 1'b0;
    stall           = 1'b0;
    redirect_valid  = 1'b0;
    redirect_target = 32'd0;
    doReset();

    // Reset release, first fetch at 0, then stall for three cycles with if_pc=4.
    repeat (3) applyStimulus(1'b0, 1'b0, 32'd0);
    repeat (3) applyStimulus(1'b1, 1'b0, 32'd0);
    repeat (2) applyStimulus(1'b0, 1'b0, 32'd0);

    // Redirect with simultaneous stall, then a misaligned redirect.
    applyStimulus(1'b1, 1'b1, 32'h10);
    repeat (2) applyStimulus(1'b0, 1'b0, 32'd0);
    applyStimulus(1'b0, 1'b1, 32'h6);
    repeat (3) applyStimulus(1'b0, 1'b0, 32'd0);

    // Run off the end of memory, stall in HALT, out-of-range then in-range redirect.
    applyStimulus(1'b0, 1'b1, 32'h3E8);
    repeat (9) applyStimulus(1'b0, 1'b0, 32'd0);
    repeat (2) applyStimulus(1'b1, 1'b0, 32'd0);
    applyStimulus(1'b0, 1'b1, 32'h800);
    repeat (2) applyStimulus(1'b0, 1'b0, 32'd0);
    applyStimulus(1'b0, 1'b1, 32'h0);
    repeat (3) applyStimulus(1'b0, 1'b0, 32'd0);

    // Reset mid-stall.
    repeat (2) applyStimulus(1'b1, 1'b0, 32'd0);
    doReset();

    for (int i = 0; i < 1500; i++) begin
      s = ($urandom_range(0, 3) == 0);
      r = ($urandom_range(0, 15) == 0);
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4, 5: tgt = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
        6, 7:             tgt = 32'($urandom_range(0, 1023));
        8:                tgt = 32'h400 + 32'($urandom_range(0, 4095));
        default:          tgt = $urandom;
      endcase
      applyStimulus(s, r, tgt);
      if (i % 400 == 399) doReset();
    end

    applyStimulus(1'b0, 1'b0, 32'd0);
    @(negedge clk);
    #1;
    checkOutput("fetch_q_drained", 32'(fetch_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
